ale_stream_param: RTL

Parametrised, streaming successor to the fixed 512×512 atmospheric-light estimator in the dehazing pipeline. It consumes one packed RGB pixel per valid cycle and selects the brightest dark-channel pixel of each frame as atmospheric light A. It optionally smooths A across frames and computes a fixed-point reciprocal of each channel with a sequential divider. It sits between the pixel source and the transmission-estimation stage, which consumes A and 1/A.

---
 rtl/ale_pkg.sv | 25 ++
 rtl/ale_recip_div.sv | 56 +++++
 rtl/ale_stream_param.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ale_pkg.sv
// Shared types and constants for the streaming atmospheric-light estimator.
package ale_pkg;

  typedef enum logic [1:0] {IDLE, SMOOTH, DIVIDE, DONE} ale_state_t;

  localparam int DEF_IMG_W        = 512;
  localparam int DEF_IMG_H        = 512;
  localparam int DEF_DW           = 8;
  localparam int DEF_INV_FRAC     = 16;
  localparam int DEF_INV_W        = 16;
  localparam int DEF_SMOOTH_SHIFT = 0;

  // Quotients are widened to SAT_W before clamping so one function serves any INV_W.
  localparam int SAT_W = 64;

  function automatic logic [SAT_W-1:0] sat_recip(input logic [SAT_W-1:0] quot,
                                                 input logic a_zero,
                                                 input int inv_w);
    logic [SAT_W-1:0] lim;
    lim = (SAT_W'(1) << inv_w) - SAT_W'(1);
    if (a_zero || quot > lim) return lim;
    return quot;
  endfunction

endpackage

// File: rtl/ale_recip_div.sv
// Restoring divider computing floor(2^(QW-1) / divisor), one quotient bit per cycle.
module ale_recip_div
  import ale_pkg::*;
#(
  parameter int DW = 8,
  parameter int QW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] divisor,
  output logic [QW-1:0] quot,
  output logic          done
);

  localparam int CW = $clog2(QW + 1);

  logic [DW-1:0] rem;
  logic [DW-1:0] d;
  logic [QW-1:0] num;
  logic [CW-1:0] cnt;
  logic          busy;
  logic [DW:0]   trial;
  logic          ge;

  // Remainder stays below the divisor, so DW bits plus the shifted-in bit suffice.
  assign trial = {rem, num[QW-1]};
  assign ge    = trial >= {1'b0, d};
  // High in the cycle whose closing edge produces the final quotient bit.
  assign done  = busy && (cnt == CW'(QW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem  <= '0;
      d    <= '0;
      num  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      quot <= '0;
    end else if (start) begin
      d    <= divisor;
      rem  <= '0;
      num  <= {1'b1, {(QW-1){1'b0}}};
      cnt  <= '0;
      busy <= 1'b1;
      quot <= '0;
    end else if (busy) begin
      num  <= num << 1;
      quot <= {quot[QW-2:0], ge};
      rem  <= ge ? DW'(trial - {1'b0, d}) : trial[DW-1:0];
      cnt  <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ale_stream_param.sv
// Streaming atmospheric-light estimator: per-frame brightest dark-channel pixel,
// optional temporal smoothing and per-channel fixed-point reciprocal.
module ale_stream_param
  import ale_pkg::*;
#(
  parameter int IMG_W        = DEF_IMG_W,
  parameter int IMG_H        = DEF_IMG_H,
  parameter int DW           = DEF_DW,
  parameter int INV_FRAC     = DEF_INV_FRAC,
  parameter int INV_W        = DEF_INV_W,
  parameter int SMOOTH_SHIFT = DEF_SMOOTH_SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3*DW-1:0]   i_pixel_data,
  input  logic              i_pixel_data_valid,
  output logic [DW-1:0]     o_a_r,
  output logic [DW-1:0]     o_a_g,
  output logic [DW-1:0]     o_a_b,
  output logic [INV_W-1:0]  o_inv_a_r,
  output logic [INV_W-1:0]  o_inv_a_g,
  output logic [INV_W-1:0]  o_inv_a_b,
  output logic              o_ale_valid,
  output logic              o_intr,
  output logic              o_overrun
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int LW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int SW = DW + 2;
  localparam int QW = INV_FRAC + 1;

  ale_state_t    state;
  logic [CW-1:0] col;
  logic [LW-1:0] line;
  logic [DW-1:0] px_r, px_g, px_b, px_dark;
  logic [SW-1:0] px_sum, best_sum;
  logic [DW-1:0] best_r, best_g, best_b, best_dark;
  logic [DW-1:0] snap_r, snap_g, snap_b;
  logic [DW-1:0] a_cur_r, a_cur_g, a_cur_b;
  logic [DW-1:0] sm_r, sm_g, sm_b;
  logic          prev_valid;
  logic          col_last, line_last, first_px, frame_last, take, snap_go;
  logic [QW-1:0] q_r, q_g, q_b;
  logic          done_r, done_g, done_b;

  assign {px_r, px_g, px_b} = i_pixel_data;

  always_comb begin
    px_dark = px_r;
    if (px_g < px_dark) px_dark = px_g;
    if (px_b < px_dark) px_dark = px_b;
  end

  assign px_sum     = SW'(px_r) + SW'(px_g) + SW'(px_b);
  assign col_last   = col == CW'(IMG_W - 1);
  assign line_last  = line == LW'(IMG_H - 1);
  assign first_px   = (col == '0) && (line == '0);
  assign frame_last = col_last && line_last;
  // Strict comparisons keep the earlier pixel on a full tie.
  assign take       = first_px || (px_dark > best_dark) ||
                      ((px_dark == best_dark) && (px_sum > best_sum));
  assign snap_go    = i_pixel_data_valid && frame_last && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      line      <= '0;
      best_r    <= '0;
      best_g    <= '0;
      best_b    <= '0;
      best_dark <= '0;
      best_sum  <= '0;
      snap_r    <= '0;
      snap_g    <= '0;
      snap_b    <= '0;
      o_intr    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_intr    <= 1'b0;
      o_overrun <= 1'b0;
      if (i_pixel_data_valid) begin
        o_intr <= col_last;
        col    <= col_last ? '0 : col + CW'(1);
        if (col_last) line <= line_last ? '0 : line + LW'(1);
        if (frame_last) begin
          best_r    <= '0;
          best_g    <= '0;
          best_b    <= '0;
          best_dark <= '0;
          best_sum  <= '0;
          if (state == IDLE) begin
            snap_r <= take ? px_r : best_r;
            snap_g <= take ? px_g : best_g;
            snap_b <= take ? px_b : best_b;
          end else begin
            o_overrun <= 1'b1;
          end
        end else if (take) begin
          best_r    <= px_r;
          best_g    <= px_g;
          best_b    <= px_b;
          best_dark <= px_dark;
          best_sum  <= px_sum;
        end
      end
    end
  end

  function automatic logic [DW-1:0] smooth(input logic [DW-1:0] cur, input logic [DW-1:0] prev);
    logic signed [DW:0] diff, step, acc;
    diff = $signed({1'b0, cur}) - $signed({1'b0, prev});
    step = diff >>> SMOOTH_SHIFT;
    acc  = $signed({1'b0, prev}) + step;
    return acc[DW-1:0];
  endfunction

  always_comb begin
    sm_r = snap_r;
    sm_g = snap_g;
    sm_b = snap_b;
    if (SMOOTH_SHIFT != 0 && prev_valid) begin
      sm_r = smooth(snap_r, a_cur_r);
      sm_g = smooth(snap_g, a_cur_g);
      sm_b = smooth(snap_b, a_cur_b);
    end
  end

  // Dividers latch the smoothed value on the same edge that registers it.
  ale_recip_div #(.DW(DW), .QW(QW)) u_div_r (
    .clk(clk), .rst(rst), .start(state == SMOOTH), .divisor(sm_r), .quot(q_r), .done(done_r));
  ale_recip_div #(.DW(DW), .QW(QW)) u_div_g (
    .clk(clk), .rst(rst), .start(state == SMOOTH), .divisor(sm_g), .quot(q_g), .done(done_g));
  ale_recip_div #(.DW(DW), .QW(QW)) u_div_b (
    .clk(clk), .rst(rst), .start(state == SMOOTH), .divisor(sm_b), .quot(q_b), .done(done_b));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_cur_r     <= '0;
      a_cur_g     <= '0;
      a_cur_b     <= '0;
      prev_valid  <= 1'b0;
      o_a_r       <= '0;
      o_a_g       <= '0;
      o_a_b       <= '0;
      o_inv_a_r   <= '0;
      o_inv_a_g   <= '0;
      o_inv_a_b   <= '0;
      o_ale_valid <= 1'b0;
    end else begin
      o_ale_valid <= 1'b0;
      case (state)
        IDLE: if (snap_go) state <= SMOOTH;
        SMOOTH: begin
          a_cur_r    <= sm_r;
          a_cur_g    <= sm_g;
          a_cur_b    <= sm_b;
          prev_valid <= 1'b1;
          state      <= DIVIDE;
        end
        DIVIDE: if (done_r && done_g && done_b) state <= DONE;
        DONE: begin
          o_a_r       <= a_cur_r;
          o_a_g       <= a_cur_g;
          o_a_b       <= a_cur_b;
          o_inv_a_r   <= INV_W'(sat_recip(SAT_W'(q_r), a_cur_r == '0, INV_W));
          o_inv_a_g   <= INV_W'(sat_recip(SAT_W'(q_g), a_cur_g == '0, INV_W));
          o_inv_a_b   <= INV_W'(sat_recip(SAT_W'(q_b), a_cur_b == '0, INV_W));
          o_ale_valid <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
